// File: rtl/parity_rx_pkg.sv
// Shared definitions for the even-parity serial link: receiver state encoding
// and the parity reduction used by both generator and receiver.
package parity_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Widest data word either side of the link supports.
  localparam int unsigned MAX_DATA_W = 16;

  // Returns 1 when data plus parity bit hold an odd number of ones, i.e. the
  // even-parity check failed. Narrower words are zero-extended by the caller.
  function automatic logic even_parity_fail(input logic [MAX_DATA_W-1:0] data,
                                            input logic                  par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous level. Resets to 1 so an idle-high
// serial line does not look like a start edge when reset is released.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/parity_frame_rx.sv
// Serial receiver for even-parity frames: start(0), DATA_W data bits LSB
// first, one even-parity bit, stop(1). Each bit is sampled once at mid-period.
module parity_frame_rx
  import parity_rx_pkg::*;
#(
  parameter int unsigned DATA_W       = 4,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);

  logic              rx_s;
  logic              rx_prev;
  rx_state_t         state;
  logic [CNT_W-1:0]  clk_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              parity_bit;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rx_s)
  );

  // History flop for falling-edge start detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev <= 1'b1;
    end else begin
      rx_prev <= rx_s;
    end
  end

  // Frame FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          clk_cnt <= '0;
          // Edge rule: a line that stays low (e.g. after a bad stop) never retriggers.
          if (rx_prev && !rx_s) begin
            state <= ST_START;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              // Glitch shorter than half a bit: drop it silently.
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt <= '0;
            // Shift in from the top so the first (LSB) bit lands at bit 0.
            shift   <= (shift >> 1) | (DATA_W'(rx_s) << (DATA_W - 1));
            if (bit_cnt == LAST_BIT) begin
              state <= ST_PARITY;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        ST_PARITY: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt    <= '0;
            parity_bit <= rx_s;
            state      <= ST_STOP;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (clk_cnt == FULL_LAST) begin
            // Back to IDLE mid stop bit so a following start edge is caught at once.
            clk_cnt    <= '0;
            state      <= ST_IDLE;
            busy       <= 1'b0;
            data_out   <= shift;
            data_valid <= 1'b1;
            parity_err <= even_parity_fail(MAX_DATA_W'(shift), parity_bit);
            frame_err  <= ~rx_s;
          end else begin
            clk_cnt <= clk_cnt + CNT_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          clk_cnt <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx with a scoreboard of expected frames.
module tb_parity_frame_rx;

  localparam int unsigned DW  = 4;
  localparam int unsigned CPB = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_in = 1'b1;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          parity_err;
  logic          frame_err;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  // {data, parity_err, frame_err}
  logic [DW+1:0] exp_q[$];
  logic [DW-1:0] last_data = '0;
  logic          prev_valid = 1'b0;

  parity_frame_rx #(
    .DATA_W       (DW),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx_in = v;
    wait_cycles(CPB);
  endtask

  // Drives one whole frame and records what the receiver must report for it.
  task automatic send_frame(input logic [DW-1:0] d, input logic par, input logic stop);
    exp_q.push_back({d, (^d) ^ par, ~stop});
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    drive_bit(par);
    drive_bit(stop);
  endtask

  // Output monitor on the falling edge, away from the active clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid) begin
        logic [DW+1:0] e;
        check("pulse_width", {15'd0, prev_valid}, 16'd0);
        check("pulse_expected", {15'd0, exp_q.size() != 0}, 16'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("data_out", 16'(data_out), 16'(e[DW+1:2]));
          check("parity_err", {15'd0, parity_err}, {15'd0, e[1]});
          check("frame_err", {15'd0, frame_err}, {15'd0, e[0]});
          check("busy_at_valid", {15'd0, busy}, 16'd0);
          last_data = e[DW+1:2];
        end
      end
      prev_valid = data_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  initial begin
    // Reset state
    wait_cycles(3);
    check("rst_data_out", 16'(data_out), 16'd0);
    check("rst_valid", {15'd0, data_valid}, 16'd0);
    check("rst_perr", {15'd0, parity_err}, 16'd0);
    check("rst_ferr", {15'd0, frame_err}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    rst = 1'b0;
    wait_cycles(CPB);

    // 1: good frame 4'hB
    send_frame(4'hB, 1'b1, 1'b1);
    wait_cycles(CPB);
    check("t1_busy_after", {15'd0, busy}, 16'd0);

    // 2: parity error, then all-zero good frame
    send_frame(4'hB, 1'b0, 1'b1);
    wait_cycles(CPB);
    send_frame(4'h0, 1'b0, 1'b1);
    wait_cycles(CPB);

    // 3: framing error, line then held low must not retrigger
    send_frame(4'h6, 1'b0, 1'b0);
    rx_in = 1'b0;
    wait_cycles(40);
    check("t3_no_retrigger_busy", {15'd0, busy}, 16'd0);
    rx_in = 1'b1;
    wait_cycles(CPB);

    // 4: short low glitch is a false start
    rx_in = 1'b0;
    wait_cycles(4);
    rx_in = 1'b1;
    for (int i = 0; i < 10 && !busy; i++) wait_cycles(1);
    check("t4_busy_seen", {15'd0, busy}, 16'd1);
    wait_cycles(30);
    check("t4_busy_cleared", {15'd0, busy}, 16'd0);
    check("t4_data_held", 16'(data_out), 16'(last_data));

    // 5: async reset mid DATA of 4'h9 aborts the frame
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_data_out", 16'(data_out), 16'd0);
    check("t5_rst_busy", {15'd0, busy}, 16'd0);
    check("t5_rst_valid", {15'd0, data_valid}, 16'd0);
    rx_in = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    last_data = '0;
    wait_cycles(CPB);
    send_frame(4'h5, 1'b0, 1'b1);
    wait_cycles(CPB);

    // 6: back-to-back frames
    send_frame(4'hA, 1'b0, 1'b1);
    send_frame(4'h7, 1'b1, 1'b1);
    rx_in = 1'b1;

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) wait_cycles(1);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    wait_cycles(20);
    check("final_busy", {15'd0, busy}, 16'd0);
    check("final_data_out", 16'(data_out), 16'h7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
